// File: rtl/sa_cache_fsm.sv
// sa_cache_fsm: N-way set-associative write-back, write-allocate cache controller with round-robin replacement
module sa_cache_fsm #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS = 1024,
  parameter int WAYS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [WORD_W-1:0] cpu_req_data,
  input  logic cpu_req_rw,
  input  logic cpu_req_valid,
  output logic cpu_req_ready,
  output logic [WORD_W-1:0] cpu_res_data,
  output logic cpu_res_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [WORD_W*LINE_WORDS-1:0] mem_req_data,
  output logic mem_req_rw,
  output logic mem_req_valid,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_data,
  input  logic mem_data_ready
);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int WSEL_W = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam int OFF_W = BYTE_W + $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_data;
  logic req_rw;
  logic [WAY_W-1:0] victim_q;
  logic [WORD_W-1:0] res_q;
  logic mem_v;
  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [LINE_W-1:0] data_mem [WAYS][SETS];
  logic [SETS-1:0] vld [WAYS];
  logic [SETS-1:0] drt [WAYS];
  logic [WAY_W-1:0] rr_ptr [SETS];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [WSEL_W-1:0] wsel;
  logic hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;
  logic done;
  logic accept;
  logic fill;
  logic unused_addr;
  assign idx = req_addr[OFF_W +: IDX_W];
  assign tag = req_addr[ADDR_W-1 -: TAG_W];
  assign wsel = LINE_WORDS > 1 ? req_addr[BYTE_W +: WSEL_W] : '0;
  assign unused_addr = ^req_addr;
  assign done = mem_v && mem_data_ready;
  assign accept = cpu_req_ready && cpu_req_valid;
  assign fill = state == ALLOCATE && done;
  assign hit_line = data_mem[hit_way][idx];
  assign hit_word = hit_line[wsel*WORD_W +: WORD_W];
  assign cpu_req_ready = state == IDLE;
  assign cpu_res_ready = state == COMPARE_TAG && hit;
  assign cpu_res_data = cpu_res_ready && !req_rw ? hit_word : res_q;
  assign mem_req_valid = mem_v;
  assign mem_req_rw = state == WRITE_BACK;
  assign mem_req_addr = state == WRITE_BACK ? {tag_mem[victim_q][idx], idx, {OFF_W{1'b0}}} :
                        state == ALLOCATE ? {tag, idx, {OFF_W{1'b0}}} : '0;
  assign mem_req_data = state == WRITE_BACK ? data_mem[victim_q][idx] : '0;
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vic = rr_ptr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld[w][idx] && tag_mem[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vld[w][idx]) vic = WAY_W'(w);
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        state_n = cpu_req_valid ? COMPARE_TAG : IDLE;
      COMPARE_TAG: state_n = hit ? IDLE : (vld[vic][idx] && drt[vic][idx]) ? WRITE_BACK : ALLOCATE;
      WRITE_BACK:  state_n = done ? ALLOCATE : WRITE_BACK;
      ALLOCATE:    state_n = done ? COMPARE_TAG : ALLOCATE;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_v <= 1'b0;
      res_q <= '0;
      req_addr <= '0;
      req_data <= '0;
      req_rw <= 1'b0;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        vld[w] <= '0;
        drt[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      state <= state_n;
      mem_v <= (state_n == WRITE_BACK || state_n == ALLOCATE) && !done;
      if (accept) begin
        req_addr <= cpu_req_addr;
        req_data <= cpu_req_data;
        req_rw <= cpu_req_rw;
      end
      if (state == COMPARE_TAG && !hit) victim_q <= vic;
      if (cpu_res_ready && !req_rw) res_q <= hit_word;
      if (cpu_res_ready && req_rw) drt[hit_way][idx] <= 1'b1;
      if (fill) begin
        vld[victim_q][idx] <= 1'b1;
        drt[victim_q][idx] <= 1'b0;
        rr_ptr[idx] <= WAYS > 1 ? victim_q + 1'b1 : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (cpu_res_ready && req_rw) data_mem[hit_way][idx][wsel*WORD_W +: WORD_W] <= req_data;
    if (fill) begin
      data_mem[victim_q][idx] <= mem_data;
      tag_mem[victim_q][idx] <= tag;
    end
  end
endmodule

// File: tb/tb_sa_cache_fsm.sv
// tb_sa_cache_fsm: directed self-checking bench for sa_cache_fsm with default parameters
module tb_sa_cache_fsm;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] cpu_req_addr, cpu_req_data, cpu_res_data, mem_req_addr;
  logic cpu_req_rw, cpu_req_valid, cpu_req_ready, cpu_res_ready;
  logic [127:0] mem_req_data, mem_data;
  logic mem_req_rw, mem_req_valid, mem_data_ready;
  int checks = 0;
  int fails = 0;
  logic [31:0] r_data, r_wb_addr, r_fill_addr;
  logic [127:0] r_wb_data;
  int r_resp, r_lat, r_wb, r_fill, r_unstable, r_pulsed;
  always #5 clk = ~clk;
  sa_cache_fsm dut (
    .clk(clk), .rst(rst),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_rw(cpu_req_rw),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_rw(mem_req_rw),
    .mem_req_valid(mem_req_valid), .mem_data(mem_data), .mem_data_ready(mem_data_ready)
  );
  function automatic logic [127:0] fill_line(input logic [31:0] a);
    return a == 32'h12345670 ? 128'h00112233445566778899aabbccddeeff : {a, ~a, a, ~a};
  endfunction
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic rw, input logic busy_pulse);
    int wait_c;
    logic prev_v;
    logic [31:0] prev_addr;
    r_resp = 0; r_lat = -1; r_wb = 0; r_fill = 0; r_unstable = 0; r_pulsed = 0;
    r_data = '0; r_wb_addr = '0; r_fill_addr = '0; r_wb_data = '0;
    @(negedge clk);
    cpu_req_addr = a; cpu_req_data = d; cpu_req_rw = rw; cpu_req_valid = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    wait_c = 0; prev_v = 1'b0; prev_addr = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      cpu_req_valid = 1'b0;
      mem_data_ready = 1'b0;
      if (cpu_res_ready) begin
        r_resp++;
        if (r_lat < 0) begin
          r_lat = cyc;
          r_data = cpu_res_data;
        end
      end
      if (mem_req_valid) begin
        if (!prev_v) begin
          if (mem_req_rw) begin
            r_wb++; r_wb_addr = mem_req_addr; r_wb_data = mem_req_data;
          end else begin
            r_fill++; r_fill_addr = mem_req_addr;
          end
        end else if (mem_req_addr !== prev_addr) r_unstable++;
        if (busy_pulse && mem_req_rw && r_pulsed == 0) begin
          r_pulsed = 1;
          cpu_req_valid = 1'b1; cpu_req_addr = 32'h55555550; cpu_req_rw = 1'b1; cpu_req_data = 32'hffffffff;
        end
        wait_c++;
        if (wait_c == 3) begin
          mem_data_ready = 1'b1;
          mem_data = fill_line(mem_req_addr);
        end
      end else wait_c = 0;
      prev_v = mem_req_valid;
      prev_addr = mem_req_addr;
      if (r_lat >= 0 && cyc >= r_lat + 3) break;
      @(negedge clk);
    end
    cpu_req_valid = 1'b0;
    mem_data_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cpu_req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", cpu_req_ready); end
    checks++; if (cpu_res_ready !== 1'b0) begin fails++; $display("FAIL reset_res_ready: got %b expected 0", cpu_res_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid: got %b expected 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_req_addr); end
    checks++; if (cpu_res_data !== 32'h0) begin fails++; $display("FAIL reset_res_data: got %h expected 0", cpu_res_data); end
    rst = 1'b0;
  endtask
  task automatic test_read_miss();
    run_req(32'h12345678, 32'h0, 1'b0, 1'b0);
    checks++; if (r_fill !== 1) begin fails++; $display("FAIL miss_fill_count: got %0d expected 1", r_fill); end
    checks++; if (r_wb !== 0) begin fails++; $display("FAIL miss_wb_count: got %0d expected 0", r_wb); end
    checks++; if (r_fill_addr !== 32'h12345670) begin fails++; $display("FAIL miss_fill_addr: got %h expected 12345670", r_fill_addr); end
    checks++; if (r_data !== 32'h44556677) begin fails++; $display("FAIL miss_data: got %h expected 44556677", r_data); end
    checks++; if (r_resp !== 1) begin fails++; $display("FAIL miss_resp_count: got %0d expected 1", r_resp); end
    checks++; if (r_lat !== 5) begin fails++; $display("FAIL miss_latency: got %0d expected 5", r_lat); end
    checks++; if (r_unstable !== 0) begin fails++; $display("FAIL miss_addr_stable: got %0d changes expected 0", r_unstable); end
  endtask
  task automatic test_read_hit();
    run_req(32'h12345678, 32'h0, 1'b0, 1'b0);
    checks++; if (r_fill + r_wb !== 0) begin fails++; $display("FAIL hit_mem_traffic: got %0d expected 0", r_fill + r_wb); end
    checks++; if (r_lat !== 1) begin fails++; $display("FAIL hit_latency: got %0d expected 1", r_lat); end
    checks++; if (r_data !== 32'h44556677) begin fails++; $display("FAIL hit_data: got %h expected 44556677", r_data); end
    checks++; if (r_resp !== 1) begin fails++; $display("FAIL hit_resp_count: got %0d expected 1", r_resp); end
  endtask
  task automatic test_write_hit();
    run_req(32'h12345674, 32'hdeadbeef, 1'b1, 1'b0);
    checks++; if (r_fill + r_wb !== 0) begin fails++; $display("FAIL wr_mem_traffic: got %0d expected 0", r_fill + r_wb); end
    checks++; if (r_resp !== 1 || r_lat !== 1) begin fails++; $display("FAIL wr_resp: got %0d pulses lat %0d expected 1 lat 1", r_resp, r_lat); end
    run_req(32'h12345674, 32'h0, 1'b0, 1'b0);
    checks++; if (r_fill + r_wb !== 0) begin fails++; $display("FAIL wr_rd_mem_traffic: got %0d expected 0", r_fill + r_wb); end
    checks++; if (r_data !== 32'hdeadbeef) begin fails++; $display("FAIL wr_rd_data: got %h expected deadbeef", r_data); end
  endtask
  task automatic test_dirty_evict();
    run_req(32'h22345670, 32'h0, 1'b0, 1'b0);
    checks++; if (r_wb !== 0 || r_fill !== 1) begin fails++; $display("FAIL way1_traffic: got wb %0d fill %0d expected 0 1", r_wb, r_fill); end
    checks++; if (r_data !== 32'hddcba98f) begin fails++; $display("FAIL way1_data: got %h expected ddcba98f", r_data); end
    run_req(32'h32345670, 32'h0, 1'b0, 1'b0);
    checks++; if (r_wb !== 1) begin fails++; $display("FAIL evict_wb_count: got %0d expected 1", r_wb); end
    checks++; if (r_wb_addr !== 32'h12345670) begin fails++; $display("FAIL evict_wb_addr: got %h expected 12345670", r_wb_addr); end
    checks++; if (r_wb_data !== 128'h0011223344556677deadbeefccddeeff) begin fails++; $display("FAIL evict_wb_data: got %h expected 0011223344556677deadbeefccddeeff", r_wb_data); end
    checks++; if (r_fill !== 1 || r_fill_addr !== 32'h32345670) begin fails++; $display("FAIL evict_fill: got %0d at %h expected 1 at 32345670", r_fill, r_fill_addr); end
    checks++; if (r_data !== 32'hcdcba98f || r_resp !== 1) begin fails++; $display("FAIL evict_data: got %h x%0d expected cdcba98f x1", r_data, r_resp); end
    checks++; if (r_unstable !== 0) begin fails++; $display("FAIL evict_addr_stable: got %0d changes expected 0", r_unstable); end
  endtask
  task automatic test_reset_in_allocate();
    int seen;
    seen = 0;
    @(negedge clk);
    cpu_req_addr = 32'h12345678; cpu_req_rw = 1'b0; cpu_req_valid = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0) begin fails++; $display("FAIL rstalloc_reach: got valid %b rw %b expected 1 0", mem_req_valid, mem_req_rw); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rstalloc_mem_valid: got %b expected 0", mem_req_valid); end
    checks++; if (cpu_res_ready !== 1'b0) begin fails++; $display("FAIL rstalloc_res_ready: got %b expected 0", cpu_res_ready); end
    checks++; if (cpu_req_ready !== 1'b1) begin fails++; $display("FAIL rstalloc_req_ready: got %b expected 1", cpu_req_ready); end
    repeat (3) begin
      @(negedge clk);
      if (cpu_res_ready || mem_req_valid) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL rstalloc_quiet: got %0d active cycles expected 0", seen); end
    run_req(32'h12345678, 32'h0, 1'b0, 1'b0);
    checks++; if (r_fill !== 1 || r_wb !== 0) begin fails++; $display("FAIL rstalloc_miss: got fill %0d wb %0d expected 1 0", r_fill, r_wb); end
    checks++; if (r_data !== 32'h44556677) begin fails++; $display("FAIL rstalloc_data: got %h expected 44556677", r_data); end
  endtask
  task automatic test_busy_request();
    run_req(32'h12345670, 32'h11111111, 1'b1, 1'b0);
    checks++; if (r_fill + r_wb !== 0 || r_resp !== 1) begin fails++; $display("FAIL busy_setup_wr: got traffic %0d resp %0d expected 0 1", r_fill + r_wb, r_resp); end
    run_req(32'h22345670, 32'h0, 1'b0, 1'b0);
    checks++; if (r_wb !== 0 || r_fill !== 1) begin fails++; $display("FAIL busy_setup_fill: got wb %0d fill %0d expected 0 1", r_wb, r_fill); end
    run_req(32'h32345678, 32'h0, 1'b0, 1'b1);
    checks++; if (r_pulsed !== 1) begin fails++; $display("FAIL busy_pulse_sent: got %0d expected 1", r_pulsed); end
    checks++; if (r_resp !== 1) begin fails++; $display("FAIL busy_resp_count: got %0d expected 1", r_resp); end
    checks++; if (r_wb_addr !== 32'h12345670 || r_wb_data !== 128'h00112233445566778899aabb11111111) begin fails++; $display("FAIL busy_wb: got %h %h expected 12345670 00112233445566778899aabb11111111", r_wb_addr, r_wb_data); end
    checks++; if (r_fill !== 1 || r_fill_addr !== 32'h32345670) begin fails++; $display("FAIL busy_fill_addr: got %0d at %h expected 1 at 32345670", r_fill, r_fill_addr); end
    checks++; if (r_data !== 32'hcdcba98f) begin fails++; $display("FAIL busy_data: got %h expected cdcba98f", r_data); end
    run_req(32'h55555550, 32'h0, 1'b0, 1'b0);
    checks++; if (r_fill !== 1 || r_fill_addr !== 32'h55555550) begin fails++; $display("FAIL busy_ignored_miss: got %0d at %h expected 1 at 55555550", r_fill, r_fill_addr); end
  endtask
  initial begin
    rst = 1'b1;
    cpu_req_addr = '0; cpu_req_data = '0; cpu_req_rw = 1'b0; cpu_req_valid = 1'b0;
    mem_data = '0; mem_data_ready = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_reset_in_allocate();
    test_busy_request();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
